muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 27 ++
 rtl/muldiv_ctrl_if.sv | 32 +++
 rtl/muldiv_ctrl_div_iter.sv | 46 ++++
 rtl/muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operand width,
// divider step count, FSM state encoding and the bit positions of the
// one-hot MULT/DIV/MFHL/MTHL op fields produced by the decoder.
package muldiv_ctrl_pkg;

  localparam int DATA_W    = 32;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W     = $clog2(DIV_STEPS);

  // Op-field bit positions
  localparam int MULT_S = 0;  // mult  (signed)
  localparam int MULT_U = 1;  // multu (unsigned)
  localparam int DIV_S  = 0;  // div   (signed)
  localparam int DIV_U  = 1;  // divu  (unsigned)
  localparam int MF_LO  = 0;  // mflo
  localparam int MF_HI  = 1;  // mfhi
  localparam int MT_LO  = 0;  // mtlo
  localparam int MT_HI  = 1;  // mthi

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL     = 2'd1,
    S_DIV_RUN = 2'd2,
    S_DIV_FIX = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX-stage bundle between the decoder/pipeline (master) and the HI/LO
// unit (slave).
//   valid_in, MULT, DIV, MFHL, MTHL, flush, src_a, src_b : pipeline -> unit
//   stall, busy, hi, lo, mfhl_data                      : unit -> pipeline
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic              valid_in;
  logic [1:0]        MULT;
  logic [1:0]        DIV;
  logic [1:0]        MFHL;
  logic [1:0]        MTHL;
  logic              flush;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              stall;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] mfhl_data;

  modport master (
    output valid_in, MULT, DIV, MFHL, MTHL, flush, src_a, src_b,
    input  stall, busy, hi, lo, mfhl_data
  );

  modport slave (
    input  valid_in, MULT, DIV, MFHL, MTHL, flush, src_a, src_b,
    output stall, busy, hi, lo, mfhl_data
  );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned radix-2 restoring divider datapath: one quotient bit per step.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : capture dividend/divisor, clear remainder
//   step              : perform one shift/subtract iteration
//   dividend, divisor : unsigned operands
//   quot, rem         : quotient / remainder (valid after DATA_W steps)
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  logic [DATA_W-1:0] dvsr;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              ge;

  // Shift next dividend bit into the partial remainder and trial-subtract.
  // If the shifted value spilled into bit DATA_W it is certainly >= dvsr.
  assign shifted = {rem, quot[DATA_W-1]};
  assign diff    = {1'b0, shifted[DATA_W-1:0]} - {1'b0, dvsr};
  assign ge      = shifted[DATA_W] | ~diff[DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot <= '0;
      rem  <= '0;
      dvsr <= '0;
    end else if (load) begin
      quot <= dividend;
      rem  <= '0;
      dvsr <= divisor;
    end else if (step) begin
      quot <= {quot[DATA_W-2:0], ge};
      rem  <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide controller for the EX stage.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : muldiv_ctrl_if.slave -- op fields/operands in; stall, busy,
//              hi, lo and mfhl_data out
// mult/multu take one busy cycle, div/divu take 34 (32 steps, a sign-fix
// cycle and a commit cycle). mfhi/mflo read committed HI/LO only.
module muldiv_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_ctrl_if.slave bus
);
  import muldiv_ctrl_pkg::*;

  state_t state, state_nxt;

  logic busy, acc, op_mul, op_div, op_mt, any_op;
  logic mul_start, div_load, div_step, mt_wr;

  logic signed [DATA_W:0]   mul_a, mul_b;
  logic [2*DATA_W-1:0]      prod;
  logic                     neg_a, neg_b, sign_q, sign_r, div_zero, fix_done;
  logic [DATA_W-1:0]        abs_a, abs_b, quot, rem, q_fix, r_fix, hi, lo;
  logic [CNT_W-1:0]         cnt;

  assign busy   = (state != S_IDLE);
  assign op_mul = bus.MULT[MULT_S] | bus.MULT[MULT_U];
  assign op_div = bus.DIV[DIV_S]   | bus.DIV[DIV_U];
  assign op_mt  = bus.MTHL[MT_HI]  | bus.MTHL[MT_LO];
  assign any_op = op_mul | op_div | op_mt | bus.MFHL[MF_HI] | bus.MFHL[MF_LO];
  assign acc    = bus.valid_in & ~bus.flush & ~busy;

  assign bus.stall = ~rst & bus.valid_in & ~bus.flush & busy & any_op;
  assign bus.busy  = busy;
  assign bus.hi    = hi;
  assign bus.lo    = lo;

  always_comb begin
    bus.mfhl_data = '0;
    if (!rst) begin
      if (bus.MFHL[MF_HI])      bus.mfhl_data = hi;
      else if (bus.MFHL[MF_LO]) bus.mfhl_data = lo;
    end
  end

  // Divider works on magnitudes; signs are reapplied in S_DIV_FIX.
  assign neg_a = bus.DIV[DIV_S] & bus.src_a[DATA_W-1];
  assign neg_b = bus.DIV[DIV_S] & bus.src_b[DATA_W-1];
  assign abs_a = neg_a ? -bus.src_a : bus.src_a;
  assign abs_b = neg_b ? -bus.src_b : bus.src_b;

  // 33-bit operands carry the signed/unsigned choice; the low 64 bits of
  // the sign-extended product are the architectural result either way.
  assign prod = {{(DATA_W-1){mul_a[DATA_W]}}, mul_a}
              * {{(DATA_W-1){mul_b[DATA_W]}}, mul_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    div_load  = 1'b0;
    div_step  = 1'b0;
    mt_wr     = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc) begin
          if (op_mul) begin
            mul_start = 1'b1;
            state_nxt = S_MUL;
          end else if (op_div) begin
            div_load  = 1'b1;
            state_nxt = S_DIV_RUN;
          end else if (op_mt) begin
            mt_wr = 1'b1;
          end
        end
      end
      S_MUL:     state_nxt = S_IDLE;
      S_DIV_RUN: begin
        div_step = 1'b1;
        if (cnt == CNT_W'(DIV_STEPS - 1)) state_nxt = S_DIV_FIX;
      end
      S_DIV_FIX: if (fix_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  div_iter #(.DATA_W(DATA_W)) u_div_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (abs_a),
    .divisor  (abs_b),
    .quot     (quot),
    .rem      (rem)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a    <= '0;
      mul_b    <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      div_zero <= 1'b0;
      fix_done <= 1'b0;
      cnt      <= '0;
      q_fix    <= '0;
      r_fix    <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      // Operand capture on acceptance
      if (mul_start) begin
        mul_a <= {bus.MULT[MULT_S] & bus.src_a[DATA_W-1], bus.src_a};
        mul_b <= {bus.MULT[MULT_S] & bus.src_b[DATA_W-1], bus.src_b};
      end
      if (div_load) begin
        sign_q   <= neg_a ^ neg_b;
        sign_r   <= neg_a;
        div_zero <= (bus.src_b == '0);
        fix_done <= 1'b0;
        cnt      <= '0;
      end
      if (div_step) cnt <= cnt + CNT_W'(1);

      // Sign fix: first S_DIV_FIX cycle. A zero divisor leaves rem equal to
      // |a|, so restoring the dividend sign gives hi = src_a naturally.
      if (state == S_DIV_FIX && !fix_done) begin
        q_fix    <= div_zero ? '1 : (sign_q ? -quot : quot);
        r_fix    <= sign_r ? -rem : rem;
        fix_done <= 1'b1;
      end

      // HI/LO commit
      if (state == S_MUL) begin
        hi <= prod[2*DATA_W-1:DATA_W];
        lo <= prod[DATA_W-1:0];
      end else if (state == S_DIV_FIX && fix_done) begin
        hi <= r_fix;
        lo <= q_fix;
      end else if (mt_wr) begin
        if (bus.MTHL[MT_HI]) hi <= bus.src_a;
        if (bus.MTHL[MT_LO]) lo <= bus.src_a;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left = 0;   // busy cycles still to run; commit when it hits 0

  function automatic logic [63:0] mul_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  // returns {hi, lo}
  function automatic logic [63:0] div_ref(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; p_hi <= '0; p_lo <= '0; m_left <= 0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (bus.valid_in && !bus.flush) begin
      if (bus.MULT != 2'b00) begin
        {p_hi, p_lo} <= mul_ref(bus.MULT[0], bus.src_a, bus.src_b);
        m_left <= 1;
      end else if (bus.DIV != 2'b00) begin
        {p_hi, p_lo} <= div_ref(bus.DIV[0], bus.src_a, bus.src_b);
        m_left <= 34;
      end else begin
        if (bus.MTHL[1]) m_hi <= bus.src_a;
        if (bus.MTHL[0]) m_lo <= bus.src_a;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic        e_busy, e_stall;
    logic [31:0] e_mf;
    #3;
    if (chk_en) begin
      e_busy  = (m_left != 0);
      e_stall = !rst && bus.valid_in && !bus.flush && e_busy &&
                ({bus.MULT, bus.DIV, bus.MFHL, bus.MTHL} != 8'h0);
      e_mf    = rst ? 32'h0 : bus.MFHL[1] ? m_hi : bus.MFHL[0] ? m_lo : 32'h0;
      chk("cyc_busy",  32'(bus.busy),  32'(e_busy));
      chk("cyc_stall", 32'(bus.stall), 32'(e_stall));
      chk("cyc_hi",    bus.hi,         m_hi);
      chk("cyc_lo",    bus.lo,         m_lo);
      chk("cyc_mfhl",  bus.mfhl_data,  e_mf);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic v, input logic [1:0] mu, input logic [1:0] dv,
                        input logic [1:0] mf, input logic [1:0] mt, input logic fl,
                        input logic [31:0] a, input logic [31:0] b);
    bus.valid_in = v; bus.MULT = mu; bus.DIV = dv; bus.MFHL = mf;
    bus.MTHL = mt; bus.flush = fl; bus.src_a = a; bus.src_b = b;
  endtask

  task automatic idle_in();
    set_in(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    #3;
    while (bus.busy && n < 100) begin
      tick(); #3; n++;
    end
    if (bus.busy) begin
      checks++; failures++;
      $display("FAIL %s timeout busy=1 required=0", name);
    end
    tick();
  endtask

  // Hold an op until it is no longer stalled; report stall count and what
  // was visible in the cycle it got accepted.
  task automatic issue_hold(input logic [1:0] mu, input logic [1:0] dv, input logic [1:0] mf,
                            input logic [1:0] mt, input logic [31:0] a, input logic [31:0] b,
                            output int stalls, output logic [31:0] rd,
                            output logic [31:0] rhi, output logic [31:0] rlo);
    set_in(1'b1, mu, dv, mf, mt, 1'b0, a, b);
    stalls = 0;
    #3;
    while (bus.stall && stalls < 200) begin
      stalls++; tick(); #3;
    end
    if (bus.stall) begin
      checks++; failures++;
      $display("FAIL hold_timeout stall=1 required=0");
    end
    rd = bus.mfhl_data; rhi = bus.hi; rlo = bus.lo;
    tick();
    idle_in();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] edge_vals [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFFE};

  function automatic logic [31:0] pick_val();
    if ($urandom_range(0, 2) == 0) return edge_vals[$urandom_range(0, 6)];
    if ($urandom_range(0, 1) == 0) return 32'($urandom_range(0, 50));
    return $urandom;
  endfunction

  initial begin
    int          st;
    logic [31:0] rd, rhi, rlo;
    logic [1:0]  mu, dv, mf, mt;

    rst = 1'b1;
    idle_in();
    repeat (2) tick();
    chk_en = 1'b1;
    set_in(1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 32'h0, 32'h0);
    #3;
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_mfhl",  bus.mfhl_data,  32'h0);
    tick();
    idle_in();
    rst = 1'b0;
    #3;
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_hi",   bus.hi,        32'h0);
    chk("rst_lo",   bus.lo,        32'h0);
    tick();

    // mult -2 * 3
    set_in(1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFE, 32'd3);
    tick(); idle_in(); #3;
    chk("mult_busy_t1", 32'(bus.busy), 32'h1);
    tick(); #3;
    chk("mult_busy_t2", 32'(bus.busy), 32'h0);
    chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo", bus.lo, 32'hFFFF_FFFA);
    chk("model_mult_lo", m_lo, 32'hFFFF_FFFA);
    tick();

    // multu max * max
    set_in(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(); idle_in();
    tick(); #3;
    chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
    chk("multu_lo", bus.lo, 32'h0000_0001);
    chk("model_multu_hi", m_hi, 32'hFFFF_FFFE);
    tick();

    // div -7 / 2 with a stalled mflo behind it
    set_in(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFF9, 32'd2);
    tick();
    issue_hold(2'b00, 2'b00, 2'b01, 2'b00, 32'h0, 32'h0, st, rd, rhi, rlo);
    chk("div_mflo_stalls", 32'(st), 32'd34);
    chk("div_mflo_data",   rd,      32'hFFFF_FFFD);
    chk("div_hi",          rhi,     32'hFFFF_FFFF);
    chk("model_div_lo",    m_lo,    32'hFFFF_FFFD);

    // divide by zero, both flavours, and signed overflow
    set_in(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 32'd100, 32'd0);
    tick(); idle_in(); wait_idle("divu0"); #3;
    chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("divu0_hi", bus.hi, 32'd100);
    tick();
    set_in(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 32'hFFFF_FFFB, 32'd0);
    tick(); idle_in(); wait_idle("div0"); #3;
    chk("div0_lo", bus.lo, 32'hFFFF_FFFF);
    chk("div0_hi", bus.hi, 32'hFFFF_FFFB);
    tick();
    set_in(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    tick(); idle_in(); wait_idle("divovf"); #3;
    chk("divovf_lo", bus.lo, 32'h8000_0000);
    chk("divovf_hi", bus.hi, 32'h0);
    tick();

    // divu 10/3, flushed mthi at T+5, then stalled mthi
    set_in(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 32'd10, 32'd3);
    repeat (4) begin tick(); idle_in(); end
    tick();
    set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 32'h55, 32'h0);
    #3;
    chk("flush_stall", 32'(bus.stall), 32'h0);
    chk("flush_busy",  32'(bus.busy),  32'h1);
    tick();
    issue_hold(2'b00, 2'b00, 2'b00, 2'b10, 32'h55, 32'h0, st, rd, rhi, rlo);
    chk("mthi_stalls", 32'(st), 32'd29);
    chk("flushdiv_lo", rlo,     32'd3);
    chk("flushdiv_hi", rhi,     32'd1);
    #3;
    chk("mthi_hi", bus.hi, 32'h55);
    chk("mthi_lo", bus.lo, 32'd3);
    tick();

    // mtlo then mfhi/mflo reads
    set_in(1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 32'hA5A5, 32'h0);
    tick(); idle_in(); #3;
    chk("mtlo_lo", bus.lo, 32'hA5A5);
    chk("mtlo_hi", bus.hi, 32'h55);
    tick();
    set_in(1'b1, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 32'h0, 32'h0); #3;
    chk("mfhi_data", bus.mfhl_data, 32'h55);
    tick();
    set_in(1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 32'h0, 32'h0); #3;
    chk("mflo_data", bus.mfhl_data, 32'hA5A5);
    tick(); idle_in(); tick();

    // back-to-back: div 20 / -3, mult 7 * -3 accepted as soon as idle
    set_in(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 32'd20, 32'hFFFF_FFFD);
    tick();
    issue_hold(2'b01, 2'b00, 2'b00, 2'b00, 32'd7, 32'hFFFF_FFFD, st, rd, rhi, rlo);
    chk("b2b_stalls", 32'(st), 32'd34);
    chk("b2b_div_lo", rlo,     32'hFFFF_FFFA);
    chk("b2b_div_hi", rhi,     32'd2);
    #3;
    chk("b2b_mul_busy", 32'(bus.busy), 32'h1);
    tick(); #3;
    chk("b2b_mul_lo", bus.lo, 32'hFFFF_FFEB);
    chk("b2b_mul_hi", bus.hi, 32'hFFFF_FFFF);
    tick();

    // reset in the middle of a division
    set_in(1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 32'd12345, 32'd7);
    repeat (9) begin tick(); idle_in(); end
    tick();
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'h0);
    chk("midrst_hi",   bus.hi,        32'h0);
    chk("midrst_lo",   bus.lo,        32'h0);
    tick();
    rst = 1'b0;
    repeat (30) tick();
    #3;
    chk("midrst_nowrite_lo", bus.lo, 32'h0);
    tick();
    set_in(1'b1, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 32'd9, 32'd3);
    tick(); idle_in(); wait_idle("divu9"); #3;
    chk("divu9_lo", bus.lo, 32'd3);
    chk("divu9_hi", bus.hi, 32'd0);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      mu = 2'b00; dv = 2'b00; mf = 2'b00; mt = 2'b00;
      case ($urandom_range(0, 8))
        1: mu = 2'b01;
        2: mu = 2'b10;
        3: dv = 2'b01;
        4: dv = 2'b10;
        5: mf = 2'b10;
        6: mf = 2'b01;
        7: mt = 2'b10;
        8: mt = 2'b01;
        default: ;
      endcase
      set_in($urandom_range(0, 3) != 0, mu, dv, mf, mt, $urandom_range(0, 7) == 0,
             pick_val(), pick_val());
    end
    tick();
    rst = 1'b0;
    idle_in();
    wait_idle("final");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
